// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage. Resolves operand forwarding from EX/MEM and
//            MEM/WB, runs the ALU, flags load-use hazards and holds the
//            EX/MEM pipeline register feeding the memory stage.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [15:0]      imm,
    input  logic             alu_src,
    input  logic [REGW-1:0]  rs,
    input  logic [REGW-1:0]  rt,
    input  logic [REGW-1:0]  rd,
    input  logic             reg_dst,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             wb_reg_write,
    input  logic [REGW-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             exm_valid,
    output logic [WIDTH-1:0] exm_result,
    output logic [WIDTH-1:0] exm_store_data,
    output logic             exm_zero,
    output logic [REGW-1:0]  exm_dest,
    output logic             exm_reg_write,
    output logic             exm_mem_read,
    output logic             exm_mem_write,
    output logic             exm_mem_to_reg,
    output logic             load_use
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    logic             exm_valid_q,      exm_valid_d;
    logic [WIDTH-1:0] exm_result_q,     exm_result_d;
    logic [WIDTH-1:0] exm_store_data_q, exm_store_data_d;
    logic             exm_zero_q,       exm_zero_d;
    logic [REGW-1:0]  exm_dest_q,       exm_dest_d;
    logic             exm_reg_write_q,  exm_reg_write_d;
    logic             exm_mem_read_q,   exm_mem_read_d;
    logic             exm_mem_write_q,  exm_mem_write_d;
    logic             exm_mem_to_reg_q, exm_mem_to_reg_d;

    logic             w_exm_fwd_ok;
    logic             w_wb_fwd_ok;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_result;

    // A load in EX/MEM has no value yet, so only non-load writers forward from there.
    assign w_exm_fwd_ok = exm_valid_q & exm_reg_write_q & ~exm_mem_to_reg_q & (exm_dest_q != '0);
    assign w_wb_fwd_ok  = wb_reg_write & (wb_rd != '0);
    assign w_imm_ext    = {{(WIDTH-16){imm[15]}}, imm};

    // Forwarding muxes: the younger EX/MEM result beats MEM/WB.
    always_comb begin
        w_fwd_rs = rs_data;
        w_fwd_rt = rt_data;
        if (w_exm_fwd_ok && (exm_dest_q == rs)) begin
            w_fwd_rs = exm_result_q;
        end else if (w_wb_fwd_ok && (wb_rd == rs)) begin
            w_fwd_rs = wb_data;
        end
        if (w_exm_fwd_ok && (exm_dest_q == rt)) begin
            w_fwd_rt = exm_result_q;
        end else if (w_wb_fwd_ok && (wb_rd == rt)) begin
            w_fwd_rt = wb_data;
        end
    end

    assign w_op_b = alu_src ? w_imm_ext : w_fwd_rt;

    // ALU; unused codes produce zero and overflow is silently dropped.
    always_comb begin
        w_alu_result = '0;
        case (ALUop)
            c_OP_ADD: w_alu_result = w_fwd_rs + w_op_b;
            c_OP_SUB: w_alu_result = w_fwd_rs - w_op_b;
            c_OP_AND: w_alu_result = w_fwd_rs & w_op_b;
            c_OP_OR:  w_alu_result = w_fwd_rs | w_op_b;
            c_OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(w_fwd_rs) < $signed(w_op_b))};
            default:  w_alu_result = '0;
        endcase
    end

    // The consumer needs the loaded value in EX; stores need rt even with an immediate operand.
    assign load_use = exm_valid_q & exm_mem_read_q & (exm_dest_q != '0) & id_valid &
                      ((exm_dest_q == rs) |
                       (~alu_src & (exm_dest_q == rt)) |
                       (mem_write & (exm_dest_q == rt)));

    // EX/MEM next state: flush beats stall, stall beats load.
    always_comb begin
        exm_valid_d      = exm_valid_q;
        exm_result_d     = exm_result_q;
        exm_store_data_d = exm_store_data_q;
        exm_zero_d       = exm_zero_q;
        exm_dest_d       = exm_dest_q;
        exm_reg_write_d  = exm_reg_write_q;
        exm_mem_read_d   = exm_mem_read_q;
        exm_mem_write_d  = exm_mem_write_q;
        exm_mem_to_reg_d = exm_mem_to_reg_q;
        if (flush) begin
            exm_valid_d      = 1'b0;
            exm_result_d     = '0;
            exm_store_data_d = '0;
            exm_zero_d       = 1'b0;
            exm_dest_d       = '0;
            exm_reg_write_d  = 1'b0;
            exm_mem_read_d   = 1'b0;
            exm_mem_write_d  = 1'b0;
            exm_mem_to_reg_d = 1'b0;
        end else if (!stall) begin
            exm_valid_d      = id_valid;
            exm_result_d     = w_alu_result;
            exm_store_data_d = w_fwd_rt;
            exm_zero_d       = (w_alu_result == '0);
            exm_dest_d       = reg_dst ? rd : rt;
            exm_reg_write_d  = id_valid & reg_write;
            exm_mem_read_d   = id_valid & mem_read;
            exm_mem_write_d  = id_valid & mem_write;
            exm_mem_to_reg_d = id_valid & mem_to_reg;
        end
    end

    // EX/MEM register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_valid_q      <= 1'b0;
            exm_result_q     <= '0;
            exm_store_data_q <= '0;
            exm_zero_q       <= 1'b0;
            exm_dest_q       <= '0;
            exm_reg_write_q  <= 1'b0;
            exm_mem_read_q   <= 1'b0;
            exm_mem_write_q  <= 1'b0;
            exm_mem_to_reg_q <= 1'b0;
        end else begin
            exm_valid_q      <= exm_valid_d;
            exm_result_q     <= exm_result_d;
            exm_store_data_q <= exm_store_data_d;
            exm_zero_q       <= exm_zero_d;
            exm_dest_q       <= exm_dest_d;
            exm_reg_write_q  <= exm_reg_write_d;
            exm_mem_read_q   <= exm_mem_read_d;
            exm_mem_write_q  <= exm_mem_write_d;
            exm_mem_to_reg_q <= exm_mem_to_reg_d;
        end
    end

    assign exm_valid      = exm_valid_q;
    assign exm_result     = exm_result_q;
    assign exm_store_data = exm_store_data_q;
    assign exm_zero       = exm_zero_q;
    assign exm_dest       = exm_dest_q;
    assign exm_reg_write  = exm_reg_write_q;
    assign exm_mem_read   = exm_mem_read_q;
    assign exm_mem_write  = exm_mem_write_q;
    assign exm_mem_to_reg = exm_mem_to_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Scoreboard bench for ex_stage: directed scenarios plus random
//            traffic compared against a behavioural EX/MEM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [31:0] sd;
        logic        z;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } exm_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, id_valid, alu_src, reg_dst;
    logic [2:0]  ALUop;
    logic [31:0] rs_data, rt_data, wb_data;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd, wb_rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg, wb_reg_write;
    logic        exm_valid, exm_zero, exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg;
    logic [31:0] exm_result, exm_store_data;
    logic [4:0]  exm_dest;
    logic        load_use;

    int   n_tests = 0;
    int   n_fail  = 0;
    exm_t m;
    exm_t st_q[$];
    logic lu_q[$];

    ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .ALUop(ALUop), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_src(alu_src), .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .exm_valid(exm_valid), .exm_result(exm_result),
        .exm_store_data(exm_store_data), .exm_zero(exm_zero), .exm_dest(exm_dest),
        .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_mem_write(exm_mem_write), .exm_mem_to_reg(exm_mem_to_reg),
        .load_use(load_use)
    );

    always #5 clk = ~clk;

    function automatic exm_t dut_state();
        return '{exm_valid, exm_result, exm_store_data, exm_zero, exm_dest,
                 exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg};
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: value the instruction in EX actually reads for a source register.
    function automatic logic [31:0] src_val(input logic [4:0] src, input logic [31:0] rf);
        if (src == 0) return rf;
        if (m.v && m.rw && !m.m2r && m.dest == src) return m.res;
        if (wb_reg_write && wb_rd == src) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Issue the currently driven inputs: queue expectations and advance the model.
    task automatic go();
        logic        lu;
        logic [31:0] a, t, b, r;
        exm_t        n;
        lu = m.v && m.mr && m.dest != 0 && id_valid &&
             (m.dest == rs || (!alu_src && m.dest == rt) || (mem_write && m.dest == rt));
        a = src_val(rs, rs_data);
        t = src_val(rt, rt_data);
        b = alu_src ? {{16{imm[15]}}, imm} : t;
        r = alu(ALUop, a, b);
        if (flush) n = '0;
        else if (stall) n = m;
        else n = '{id_valid, r, t, (r == 0), (reg_dst ? rd : rt),
                   id_valid & reg_write, id_valid & mem_read,
                   id_valid & mem_write, id_valid & mem_to_reg};
        lu_q.push_back(lu);
        st_q.push_back(n);
        m = n;
    endtask

    task automatic instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic rdst, input logic asrc, input logic [15:0] im,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
        @(negedge clk);
        ALUop = op; rs_data = a; rt_data = b; rs = s; rt = t; rd = d;
        reg_dst = rdst; alu_src = asrc; imm = im;
        reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
        id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic rnd();
        @(negedge clk);
        ALUop = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
        if ($urandom_range(0, 3) == 0) rs_data = 32'hFFFF_FFF0 + 32'($urandom_range(0, 31));
        imm = 16'($urandom); alu_src = 1'($urandom); reg_dst = 1'($urandom);
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        mem_to_reg = 1'($urandom); id_valid = ($urandom_range(0, 7) != 0);
        stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 15) == 0);
        wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
        go();
    endtask

    // Monitor: combinational hazard flag, sampled mid low phase.
    always begin
        @(negedge clk);
        #2;
        if (lu_q.size() > 0) chk("load_use", 80'(load_use), 80'(lu_q.pop_front()));
    end

    // Monitor: EX/MEM contents after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (st_q.size() > 0) chk("exm_state", 80'(dut_state()), 80'(st_q.pop_front()));
    end

    initial begin
        logic [31:0] sweep_want [6];
        logic [2:0]  sweep_op   [6];
        sweep_op   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b101};
        sweep_want = '{32'd16, 32'hFFFF_FFFE, 32'd1, 32'd15, 32'd1, 32'd0};
        m = '0;
        rst = 1'b0;
        stall = 0; flush = 0; id_valid = 0; alu_src = 0; reg_dst = 0; ALUop = 0;
        rs_data = 0; rt_data = 0; wb_data = 0; imm = 0; rs = 0; rt = 0; rd = 0; wb_rd = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0; wb_reg_write = 0;
        #2;
        chk("reset_state", 80'(dut_state()), 80'd0);
        chk("reset_load_use", 80'(load_use), 80'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ALU sweep
        for (int i = 0; i < 6; i++) begin
            instr(sweep_op[i], 32'd7, 32'd9, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            go();
            @(posedge clk); #1;
            chk($sformatf("alu_op%b", sweep_op[i]), 80'(exm_result), 80'(sweep_want[i]));
        end
        chk("alu_zero_101", 80'(exm_zero), 80'd1);

        // Forwarding: EX/MEM beats MEM/WB
        instr(3'b010, 32'd5, 32'd6, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go();
        instr(3'b010, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        go();
        @(posedge clk); #1;
        chk("fwd_exm_wins", 80'(exm_result), 80'd22);

        // Register 0 never forwarded
        instr(3'b010, 32'd5, 32'd6, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go();
        instr(3'b010, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
        go();
        @(posedge clk); #1;
        chk("no_fwd_r0", 80'(exm_result), 80'd0);

        // Load-use: rs dependency stalls, rt with immediate operand does not
        instr(3'b010, 32'd100, 32'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        go();
        instr(3'b010, 32'd1, 32'd2, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("load_use_rs", 80'(load_use), 80'd1);
        go();
        instr(3'b010, 32'd100, 32'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        go();
        instr(3'b010, 32'd1, 32'd2, 5'd2, 5'd5, 5'd7, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("load_use_imm", 80'(load_use), 80'd0);
        go();

        // Stall holds for three cycles, then flush+stall clears
        instr(3'b010, 32'd5, 32'd6, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go();
        for (int i = 0; i < 3; i++) begin
            instr(3'b110, 32'd99, 32'd1, 5'd8, 5'd9, 5'd12, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            stall = 1'b1;
            go();
            @(posedge clk); #1;
            chk("stall_hold", 80'({exm_valid, exm_result, exm_dest, exm_reg_write}), 80'({1'b1, 32'd11, 5'd7, 1'b1}));
        end
        instr(3'b010, 32'd1, 32'd1, 5'd8, 5'd9, 5'd12, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        stall = 1'b1; flush = 1'b1;
        go();
        @(posedge clk); #1;
        chk("flush_wins", 80'({exm_valid, exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg}), 80'd0);

        // Sign-extended immediate wraps to zero
        instr(3'b010, 32'd1, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        go();
        @(posedge clk); #1;
        chk("imm_wrap", 80'({exm_result, exm_zero}), 80'({32'd0, 1'b1}));

        repeat (300) rnd();

        // Asynchronous reset mid-cycle
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_reset", 80'(dut_state()), 80'd0);
        chk("async_reset_lu", 80'(load_use), 80'd0);
        m = '0;
        @(negedge clk);
        rst = 1'b1;

        repeat (200) rnd();
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 80'(st_q.size() + lu_q.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, including the EX/MEM pipeline register. It takes the decoded ID/EX fields and the 3-bit ALU operation code from the ALU control unit. It forwards operands from the two later stages, computes the ALU result, and registers the result with the memory/writeback controls for the MEM stage. It also flags load-use hazards so the hazard unit can stall the front end.

## Interface
Parameters:
- WIDTH, 32, datapath width
- REGW, 5, register-index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold the EX/MEM register contents
- flush  in  1  load a bubble into the EX/MEM register
- id_valid  in  1  the ID/EX slot holds a real instruction
- ALUop  in  3  operation from ALU control
- rs_data, rt_data  in  WIDTH  register-file read values
- imm  in  16  raw immediate
- alu_src  in  1  1 = operand B is sign-extended imm
- rs, rt, rd  in  REGW  source/destination indices
- reg_dst  in  1  1 = destination is rd, 0 = rt
- reg_write, mem_read, mem_write, mem_to_reg  in  1  controls carried to MEM/WB
- wb_reg_write  in  1  MEM/WB stage writes the register file
- wb_rd  in  REGW  MEM/WB destination
- wb_data  in  WIDTH  MEM/WB write value
- exm_valid  out  1  EX/MEM slot valid
- exm_result  out  WIDTH  registered ALU result
- exm_store_data  out  WIDTH  registered forwarded rt value
- exm_zero  out  1  registered (result == 0)
- exm_dest  out  REGW  registered destination index
- exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg  out  1  registered controls
- load_use  out  1  combinational load-use hazard flag

## Operation
- Forwarding, for each of rs and rt independently:
  - Priority 1, EX/MEM: use exm_result when exm_valid & exm_reg_write & !exm_mem_to_reg & exm_dest != 0 & exm_dest == src.
  - Priority 2, MEM/WB: use wb_data when wb_reg_write & wb_rd != 0 & wb_rd == src.
  - Otherwise use the register-file value.
  - Register 0 is never forwarded.
- Operands:
  - A = forwarded rs.
  - B = alu_src ? sign-extend(imm) : forwarded rt.
  - Store data = forwarded rt, regardless of alu_src.
- ALU operations:
  - 010: add, mod 2^WIDTH.
  - 110: subtract, mod 2^WIDTH.
  - 000: bitwise AND.
  - 001: bitwise OR.
  - 111: set-less-than, signed; result 1 or 0, zero-extended.
  - 101 and all other codes: result 0.
  - Overflow is ignored; no traps.
- Destination: reg_dst ? rd : rt.
- Load-use flag: load_use = exm_valid & exm_mem_read & exm_dest != 0 & id_valid & (exm_dest == rs | (!alu_src & exm_dest == rt) | (mem_write & exm_dest == rt)).
- EX/MEM register update on each rising edge, priority order:
  - !rst: all outputs 0 immediately, asynchronously.
  - flush: exm_valid and all exm_* control bits cleared to 0; data fields cleared to 0.
  - stall: every exm_* field holds.
  - else: all fields load. exm_valid = id_valid. If !id_valid, all control bits load 0.
- flush and stall asserted together: flush wins.

## Timing
- Latency: 1 cycle from the ID/EX inputs to the exm_* outputs.
- The forwarding muxes and ALU are combinational within the cycle.
- load_use is combinational from the current exm_* state and the ID/EX inputs; no register.
- Reset values: every exm_* output is 0. load_use is 0 while in reset, since exm_valid = 0.
- Reset deasserted mid-operation: the first edge after release loads normally; there is no warm-up cycle.
- During stall, forwarding from EX/MEM uses the held contents, so a repeated instruction sees a consistent forward.
- WIDTH-bit wrap-around on add/sub, e.g. 0xFFFFFFFF + 1 = 0 with exm_zero = 1.

## Test plan
- Reset: assert rst low mid-cycle -> all exm_* outputs go to 0 at once, without waiting for a clock edge.
- ALU sweep, rs_data=7, rt_data=9, alu_src=0:
  - 010 -> 16
  - 110 -> 0xFFFFFFFE
  - 000 -> 1
  - 001 -> 15
  - 111 -> 1
  - 101 -> 0 with exm_zero=1
- Forwarding: back-to-back add r3=r1+r2 then add r4=r3+r3, with wb_rd=3 and wb_data=0x55 also presented -> the second result uses the EX/MEM value (EX/MEM wins). Also, rd=0 writes are never forwarded.
- Load-use: EX/MEM holds lw to r5 and ID/EX holds add using rs=5 -> load_use=1. The same case with rt=5 and alu_src=1 -> load_use=0.
- Control: stall for 3 cycles -> exm_* unchanged. flush together with stall -> exm_valid=0 and all controls 0 on the next edge.
- Immediate: alu_src=1, imm=0xFFFF, rs_data=1, ALUop=010 -> exm_result=0 and exm_zero=1.
